regfile_sb: RTL and testbench

- Parametrised successor to the 16x32 register file: configurable width and depth, two registered read ports, and write-to-read bypass.
- Adds an optional hardwired zero register, a synchronous reset that clears all state, and a per-register pending-write scoreboard.
- Sits between the decode stage, which reads operands and locks destinations, and the writeback stage, which writes results and releases locks.

---
 rtl/regfile_sb.sv | 136 +++++++++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb : parametrised register file with two registered read ports,
//              write-to-read bypass, optional hardwired zero register and a
//              per-register pending-write (busy) scoreboard.
//
// The decode stage presents read addresses and locks destination registers;
// the writeback stage writes results, which releases the lock on that
// register. There is no valid/ready handshake: every input is sampled on
// every posedge and every output is updated on every posedge.
//
// Parameters
//   WIDTH     data word width
//   ADDR_W    address width (depth = 2**ADDR_W)
//   ZERO_REG  1: register 0 reads 0, drops writes, is never busy
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   Rwrite/Rdst_addr/Rdst     write port
//   Rlock/Rlock_addr          mark a register as pending-write
//   Rsrc1_addr/Rsrc2_addr     read addresses
//   Rsrc1/Rsrc2               registered read data (1-cycle latency)
//   Rsrc1_busy/Rsrc2_busy     registered busy flags of the read operands
//   Rlock_conflict            registered; lock hit an already-busy register
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Rwrite,
    input  logic [ADDR_W-1:0] Rdst_addr,
    input  logic [WIDTH-1:0]  Rdst,
    input  logic              Rlock,
    input  logic [ADDR_W-1:0] Rlock_addr,
    input  logic [ADDR_W-1:0] Rsrc1_addr,
    input  logic [ADDR_W-1:0] Rsrc2_addr,
    output logic [WIDTH-1:0]  Rsrc1,
    output logic [WIDTH-1:0]  Rsrc2,
    output logic              Rsrc1_busy,
    output logic              Rsrc2_busy,
    output logic              Rlock_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [WIDTH-1:0] r_rsrc1;
    logic [WIDTH-1:0] r_rsrc2;
    logic             r_rsrc1_busy;
    logic             r_rsrc2_busy;
    logic             r_lock_conflict;

    logic             w_zero_en;
    logic             w_wr_en;
    logic             w_lock_en;
    logic [DEPTH-1:0] w_busy_next;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic             w_conflict;

    // Accesses to register 0 are neutralised when it is the hardwired zero.
    assign w_zero_en = (ZERO_REG != 0);
    assign w_wr_en   = Rwrite && !(w_zero_en && (Rdst_addr == '0));
    assign w_lock_en = Rlock && !(w_zero_en && (Rlock_addr == '0));

    // Release by write first, then lock: a same-cycle lock of the register
    // being written wins, so it stays busy for the new producer.
    always_comb begin
        w_busy_next = r_busy;
        if (Rwrite) begin
            w_busy_next[Rdst_addr] = 1'b0;
        end
        if (w_lock_en) begin
            w_busy_next[Rlock_addr] = 1'b1;
        end
        if (w_zero_en) begin
            w_busy_next[0] = 1'b0;
        end
    end

    // Read data as it stands after this edge's write (bypass).
    always_comb begin
        w_rd1 = r_mem[Rsrc1_addr];
        w_rd2 = r_mem[Rsrc2_addr];
        if (w_wr_en && (Rdst_addr == Rsrc1_addr)) begin
            w_rd1 = Rdst;
        end
        if (w_wr_en && (Rdst_addr == Rsrc2_addr)) begin
            w_rd2 = Rdst;
        end
        if (w_zero_en && (Rsrc1_addr == '0)) begin
            w_rd1 = '0;
        end
        if (w_zero_en && (Rsrc2_addr == '0)) begin
            w_rd2 = '0;
        end
    end

    // A write releasing the same register this cycle is not a conflict.
    assign w_conflict = w_lock_en && r_busy[Rlock_addr] &&
                        !(Rwrite && (Rdst_addr == Rlock_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy          <= '0;
            r_rsrc1         <= '0;
            r_rsrc2         <= '0;
            r_rsrc1_busy    <= 1'b0;
            r_rsrc2_busy    <= 1'b0;
            r_lock_conflict <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[Rdst_addr] <= Rdst;
            end
            r_busy          <= w_busy_next;
            r_rsrc1         <= w_rd1;
            r_rsrc2         <= w_rd2;
            r_rsrc1_busy    <= w_busy_next[Rsrc1_addr];
            r_rsrc2_busy    <= w_busy_next[Rsrc2_addr];
            r_lock_conflict <= w_conflict;
        end
    end

    assign Rsrc1          = r_rsrc1;
    assign Rsrc2          = r_rsrc2;
    assign Rsrc1_busy     = r_rsrc1_busy;
    assign Rsrc2_busy     = r_rsrc2_busy;
    assign Rlock_conflict = r_lock_conflict;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb : drives two regfile_sb instances (default 16x32 with zero
// register, and a 32-bit x 8 instance without zero register). The driver
// applies one operation per cycle on the falling edge, updates an
// array-based reference model and pushes the expected registered outputs;
// a monitor pops and compares after each rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: WIDTH=16, ADDR_W=5, ZERO_REG=1 ----------------
    logic        a_rst, a_wr, a_lock;
    logic [4:0]  a_waddr, a_laddr, a_a1, a_a2;
    logic [15:0] a_wdata, a_s1, a_s2;
    logic        a_b1, a_b2, a_cf;

    regfile_sb #(.WIDTH(16), .ADDR_W(5), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(a_rst), .Rwrite(a_wr), .Rdst_addr(a_waddr), .Rdst(a_wdata),
        .Rlock(a_lock), .Rlock_addr(a_laddr), .Rsrc1_addr(a_a1), .Rsrc2_addr(a_a2),
        .Rsrc1(a_s1), .Rsrc2(a_s2), .Rsrc1_busy(a_b1), .Rsrc2_busy(a_b2),
        .Rlock_conflict(a_cf)
    );

    // ---------------- DUT B: WIDTH=32, ADDR_W=3, ZERO_REG=0 ----------------
    logic        b_rst, b_wr, b_lock;
    logic [2:0]  b_waddr, b_laddr, b_a1, b_a2;
    logic [31:0] b_wdata, b_s1, b_s2;
    logic        b_b1, b_b2, b_cf;

    regfile_sb #(.WIDTH(32), .ADDR_W(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(b_rst), .Rwrite(b_wr), .Rdst_addr(b_waddr), .Rdst(b_wdata),
        .Rlock(b_lock), .Rlock_addr(b_laddr), .Rsrc1_addr(b_a1), .Rsrc2_addr(b_a2),
        .Rsrc1(b_s1), .Rsrc2(b_s2), .Rsrc1_busy(b_b1), .Rsrc2_busy(b_b2),
        .Rlock_conflict(b_cf)
    );

    // ---------------- reference model ----------------
    bit          cur_sel;       // 0: DUT A, 1: DUT B
    bit          m_zero;
    int unsigned m_depth;
    logic [31:0] m_mask;
    logic [31:0] m_reg [32];
    bit          m_busy [32];

    typedef struct packed {
        logic        sel;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        b1;
        logic        b2;
        logic        cf;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", name, cur_sel, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit rst_i, input bit wr, input int unsigned waddr,
                         input logic [31:0] wdata, input bit lock, input int unsigned laddr,
                         input int unsigned a1, input int unsigned a2);
        exp_t e;
        bit   cf;
        @(negedge clk);
        waddr = waddr % m_depth;
        laddr = laddr % m_depth;
        a1    = a1 % m_depth;
        a2    = a2 % m_depth;
        wdata = wdata & m_mask;
        if (cur_sel == 1'b0) begin
            a_rst = rst_i; a_wr = wr; a_lock = lock;
            a_waddr = waddr[4:0]; a_laddr = laddr[4:0];
            a_a1 = a1[4:0]; a_a2 = a2[4:0]; a_wdata = wdata[15:0];
        end else begin
            b_rst = rst_i; b_wr = wr; b_lock = lock;
            b_waddr = waddr[2:0]; b_laddr = laddr[2:0];
            b_a1 = a1[2:0]; b_a2 = a2[2:0]; b_wdata = wdata;
        end

        e     = '0;
        e.sel = cur_sel;
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            cf = lock && !(m_zero && laddr == 0) && m_busy[laddr] && !(wr && waddr == laddr);
            if (wr && !(m_zero && waddr == 0)) m_reg[waddr] = wdata;
            if (wr) m_busy[waddr] = 1'b0;
            if (lock && !(m_zero && laddr == 0)) m_busy[laddr] = 1'b1;
            e.s1 = (m_zero && a1 == 0) ? 32'h0 : m_reg[a1];
            e.s2 = (m_zero && a2 == 0) ? 32'h0 : m_reg[a2];
            e.b1 = (m_zero && a1 == 0) ? 1'b0 : m_busy[a1];
            e.b2 = (m_zero && a2 == 0) ? 1'b0 : m_busy[a2];
            e.cf = cf;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int unsigned a1, input int unsigned a2);
        drive(0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t        mon_e;
    logic [31:0] g1, g2;
    logic        gb1, gb2, gcf;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.sel == 1'b0) begin
                g1 = {16'h0, a_s1}; g2 = {16'h0, a_s2};
                gb1 = a_b1; gb2 = a_b2; gcf = a_cf;
            end else begin
                g1 = b_s1; g2 = b_s2;
                gb1 = b_b1; gb2 = b_b2; gcf = b_cf;
            end
            check("rsrc1", g1, mon_e.s1);
            check("rsrc2", g2, mon_e.s2);
            check("rsrc1_busy", {31'h0, gb1}, {31'h0, mon_e.b1});
            check("rsrc2_busy", {31'h0, gb2}, {31'h0, mon_e.b2});
            check("lock_conflict", {31'h0, gcf}, {31'h0, mon_e.cf});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        a_rst = 1; a_wr = 0; a_lock = 0; a_waddr = 0; a_laddr = 0; a_a1 = 0; a_a2 = 0; a_wdata = 0;
        b_rst = 1; b_wr = 0; b_lock = 0; b_waddr = 0; b_laddr = 0; b_a1 = 0; b_a2 = 0; b_wdata = 0;

        // ---- DUT A directed ----
        cur_sel = 0; m_zero = 1; m_depth = 32; m_mask = 32'h0000_FFFF;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        // reset clears data and locks
        drive(0, 1, 5, 32'hBEEF, 1, 6, 5, 6);
        drive(1, 0, 0, 0, 0, 0, 5, 6);
        idle(5, 6);
        // write then read, bypass on both ports
        drive(0, 1, 7, 32'h1234, 0, 0, 1, 2);
        idle(7, 7);
        drive(0, 1, 9, 32'hA5A5, 0, 0, 9, 9);
        // zero register
        drive(0, 1, 0, 32'hFFFF, 0, 0, 0, 0);
        idle(0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        // scoreboard lifecycle on R3
        drive(0, 0, 0, 0, 1, 3, 1, 3);
        idle(1, 3);
        drive(0, 1, 3, 32'h0042, 0, 0, 1, 3);
        drive(0, 1, 3, 32'h0077, 1, 3, 3, 3);
        idle(3, 3);
        // conflict on R4
        drive(0, 0, 0, 0, 1, 4, 4, 4);
        drive(0, 0, 0, 0, 1, 4, 4, 4);
        drive(0, 1, 4, 32'h0011, 0, 0, 4, 4);
        drive(0, 0, 0, 0, 1, 4, 4, 4);
        drive(0, 1, 4, 32'h0022, 1, 4, 4, 4);
        idle(4, 4);

        // ---- DUT A random ----
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 31));
        end

        // ---- DUT B: WIDTH=32, ADDR_W=3, ZERO_REG=0 ----
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cur_sel = 1; m_zero = 0; m_depth = 8; m_mask = 32'hFFFF_FFFF;
        a_rst = 1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'hDEADBEEF, 0, 0, 1, 2);
        drive(0, 1, 7, 32'hDEADBEEF, 0, 0, 1, 2);
        idle(0, 7);
        drive(0, 0, 0, 0, 1, 0, 0, 7);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 59) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
        end

        // ---- drain and report ----
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
